// File: rtl/bmp_pkg.sv
// Shared state encoding, BMP field constants and image size derivations
// for the BMP stream writer.
package bmp_pkg;

  localparam int HDR_LEN    = 54;
  localparam int BMP_OFFSET = 54;
  localparam int DIB_SIZE   = 40;
  localparam int BMP_BPP    = 24;
  localparam int BMP_PPM    = 2835;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PIX_WAIT,
    ST_PIX_B,
    ST_PIX_G,
    ST_PIX_R,
    ST_PAD,
    ST_DONE
  } state_t;

  // Rows are padded up to a whole number of 32-bit words.
  function automatic int row_bytes(input int w);
    return ((3 * w + 3) / 4) * 4;
  endfunction

  function automatic int pad_bytes(input int w);
    return row_bytes(w) - 3 * w;
  endfunction

  function automatic int img_size(input int w, input int h);
    return row_bytes(w) * h;
  endfunction

  function automatic int file_size(input int w, input int h);
    return HDR_LEN + img_size(w, h);
  endfunction

endpackage

// File: rtl/bmp_header_rom.sv
// Combinational lookup of the 54-byte BMP file + DIB header for a fixed
// image geometry.
module bmp_header_rom
  import bmp_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic [5:0] index,
  output logic [7:0] hdr_byte
);

  localparam logic [31:0] FILE_SZ = 32'(file_size(IMG_W, IMG_H));
  localparam logic [31:0] IMG_SZ  = 32'(img_size(IMG_W, IMG_H));

  logic [31:0] field;
  logic [5:0]  base;
  logic [5:0]  offset;

  // Select the little-endian field containing this index, then its byte lane.
  always_comb begin
    field = 32'd0;
    base  = 6'd0;
    if (index < 6'd2) begin
      field = 32'h0000_4D42;
      base  = 6'd0;
    end else if (index < 6'd6) begin
      field = FILE_SZ;
      base  = 6'd2;
    end else if (index < 6'd10) begin
      field = 32'd0;
      base  = 6'd6;
    end else if (index < 6'd14) begin
      field = 32'(BMP_OFFSET);
      base  = 6'd10;
    end else if (index < 6'd18) begin
      field = 32'(DIB_SIZE);
      base  = 6'd14;
    end else if (index < 6'd22) begin
      field = 32'(IMG_W);
      base  = 6'd18;
    end else if (index < 6'd26) begin
      field = 32'(IMG_H);
      base  = 6'd22;
    end else if (index < 6'd28) begin
      field = 32'd1;
      base  = 6'd26;
    end else if (index < 6'd30) begin
      field = 32'(BMP_BPP);
      base  = 6'd28;
    end else if (index < 6'd34) begin
      field = 32'd0;
      base  = 6'd30;
    end else if (index < 6'd38) begin
      field = IMG_SZ;
      base  = 6'd34;
    end else if (index < 6'd42) begin
      field = 32'(BMP_PPM);
      base  = 6'd38;
    end else if (index < 6'd46) begin
      field = 32'(BMP_PPM);
      base  = 6'd42;
    end else begin
      field = 32'd0;
      base  = 6'd46;
    end
    offset   = index - base;
    hdr_byte = field[{offset[1:0], 3'b000} +: 8];
  end

endmodule

// File: rtl/bmp_stream_writer.sv
// Streams a 24-bpp uncompressed BMP file: header bytes, then BGR pixel
// bytes with per-row zero padding, under valid/ready flow control.
module bmp_stream_writer
  import bmp_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        pix_ready,
  output logic        out_valid,
  output logic [7:0]  out_byte,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam int          PAD_N    = pad_bytes(IMG_W);
  localparam logic [11:0] COL_LAST = 12'(IMG_W - 1);
  localparam logic [11:0] ROW_LAST = 12'(IMG_H - 1);
  localparam logic [5:0]  HDR_LAST = 6'(HDR_LEN - 1);
  localparam logic [1:0]  PAD_LAST = 2'((PAD_N > 0) ? PAD_N - 1 : 0);

  state_t      state, state_n;
  logic [5:0]  hdr_idx, hdr_idx_n;
  logic [11:0] col, col_n;
  logic [11:0] row, row_n;
  logic [1:0]  pad_cnt, pad_cnt_n;
  logic [23:0] pix_latch, pix_latch_n;
  logic        out_valid_n;
  logic [7:0]  out_byte_n;
  logic [7:0]  hdr_byte;

  bmp_header_rom #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_header_rom (
    .index   (hdr_idx_n),
    .hdr_byte(hdr_byte)
  );

  // Output byte is loaded from next-state values, so it holds during stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      hdr_idx   <= 6'd0;
      col       <= 12'd0;
      row       <= 12'd0;
      pad_cnt   <= 2'd0;
      pix_latch <= 24'd0;
      out_valid <= 1'b0;
      out_byte  <= 8'h00;
    end else begin
      state     <= state_n;
      hdr_idx   <= hdr_idx_n;
      col       <= col_n;
      row       <= row_n;
      pad_cnt   <= pad_cnt_n;
      pix_latch <= pix_latch_n;
      out_valid <= out_valid_n;
      out_byte  <= out_byte_n;
    end
  end

  always_comb begin
    state_n     = state;
    hdr_idx_n   = hdr_idx;
    col_n       = col;
    row_n       = row;
    pad_cnt_n   = pad_cnt;
    pix_latch_n = pix_latch;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n   = ST_HEADER;
          hdr_idx_n = 6'd0;
        end
      end
      ST_HEADER: begin
        if (out_ready) begin
          if (hdr_idx == HDR_LAST) begin
            state_n   = ST_PIX_WAIT;
            hdr_idx_n = 6'd0;
          end else begin
            hdr_idx_n = hdr_idx + 6'd1;
          end
        end
      end
      ST_PIX_WAIT: begin
        if (pix_valid) begin
          pix_latch_n = pix_data;
          state_n     = ST_PIX_B;
        end
      end
      ST_PIX_B: if (out_ready) state_n = ST_PIX_G;
      ST_PIX_G: if (out_ready) state_n = ST_PIX_R;
      ST_PIX_R: begin
        if (out_ready) begin
          if (col != COL_LAST) begin
            col_n   = col + 12'd1;
            state_n = ST_PIX_WAIT;
          end else begin
            col_n = 12'd0;
            if (PAD_N > 0) begin
              pad_cnt_n = 2'd0;
              state_n   = ST_PAD;
            end else if (row == ROW_LAST) begin
              row_n   = 12'd0;
              state_n = ST_DONE;
            end else begin
              row_n   = row + 12'd1;
              state_n = ST_PIX_WAIT;
            end
          end
        end
      end
      ST_PAD: begin
        if (out_ready) begin
          if (pad_cnt == PAD_LAST) begin
            pad_cnt_n = 2'd0;
            if (row == ROW_LAST) begin
              row_n   = 12'd0;
              state_n = ST_DONE;
            end else begin
              row_n   = row + 12'd1;
              state_n = ST_PIX_WAIT;
            end
          end else begin
            pad_cnt_n = pad_cnt + 2'd1;
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid_n = 1'b0;
    out_byte_n  = 8'h00;
    pix_ready   = (state == ST_PIX_WAIT);
    busy        = (state != ST_IDLE);
    done        = (state == ST_DONE);
    unique case (state_n)
      ST_HEADER: begin
        out_valid_n = 1'b1;
        out_byte_n  = hdr_byte;
      end
      ST_PIX_B: begin
        out_valid_n = 1'b1;
        out_byte_n  = pix_latch_n[7:0];
      end
      ST_PIX_G: begin
        out_valid_n = 1'b1;
        out_byte_n  = pix_latch_n[15:8];
      end
      ST_PIX_R: begin
        out_valid_n = 1'b1;
        out_byte_n  = pix_latch_n[23:16];
      end
      ST_PAD: begin
        out_valid_n = 1'b1;
        out_byte_n  = 8'h00;
      end
      default: begin
        out_valid_n = 1'b0;
        out_byte_n  = 8'h00;
      end
    endcase
  end

endmodule
